resize_sched: RTL and testbench

Frame scheduler for the `resize` 4:1 downscaler. It converts software/accelerator frame requests into start toggles for the downscaler and counts the `H_OUTPUT*V_OUTPUT` output pixels. It also generates write enables and addresses into a two-entry ping-pong frame buffer and tracks buffer ownership with the downstream consumer (the detection engine). It sits between the video timing domain and the frame-buffer writer, on the same clock as `resize`.

---
 rtl/resize_pkg.sv | 23 ++
 rtl/resize_sched_if.sv | 41 ++++
 rtl/resize_buf_sel.sv | 43 ++++
 rtl/resize_sched.sv | 160 ++++++++++++++++
 tb/tb_resize_sched.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/resize_pkg.sv
// Shared types and constants for the resize frame scheduler and its buffer selector.
package resize_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;

    localparam int PIX_W = 17;
    localparam int TMO_W = 23;

    function automatic int frame_total(input int h_output, input int v_output);
        return h_output * v_output;
    endfunction

endpackage

// File: rtl/resize_sched_if.sv
// Signal bundle between the frame scheduler and its surroundings (requests, pixels, frame-buffer port).
interface resize_sched_if;
    import resize_pkg::*;

    // i_req/i_abort/i_sof/i_buf_rel are single-cycle pulses and i_cont is a level.
    // i_px_de is a valid with no ready: every pixel is taken while armed or running.
    // o_wr_en is a valid with no ready: the frame buffer accepts every write it sees.
    logic                   i_req;
    logic                   i_cont;
    logic                   i_abort;
    logic                   i_sof;
    logic                   i_px_de;
    logic [23:0]            i_px_data;
    logic [1:0]             i_buf_rel;

    logic                   o_start;
    logic                   o_busy;
    logic                   o_wr_en;
    logic                   o_wr_buf;
    logic [PIX_W-1:0]       o_wr_addr;
    logic [23:0]            o_wr_data;
    logic [1:0]             o_buf_full;
    logic                   o_done;
    logic                   o_done_buf;
    logic                   o_err;
    logic [1:0]             o_err_code;
    state_t                 o_state;

    modport master (
        output i_req, i_cont, i_abort, i_sof, i_px_de, i_px_data, i_buf_rel,
        input  o_start, o_busy, o_wr_en, o_wr_buf, o_wr_addr, o_wr_data,
               o_buf_full, o_done, o_done_buf, o_err, o_err_code, o_state
    );

    modport slave (
        input  i_req, i_cont, i_abort, i_sof, i_px_de, i_px_data, i_buf_rel,
        output o_start, o_busy, o_wr_en, o_wr_buf, o_wr_addr, o_wr_data,
               o_buf_full, o_done, o_done_buf, o_err, o_err_code, o_state
    );

endinterface

// File: rtl/resize_buf_sel.sv
// Ping-pong buffer ownership: full bits, last-written buffer and next-buffer choice.
module resize_buf_sel (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_rel,
    input  logic       i_set,
    input  logic       i_set_buf,
    output logic [1:0] o_full,
    output logic       o_avail,
    output logic       o_sel
);

    logic [1:0] full_q, full_d;
    logic       last_q, last_d;
    logic       pref;

    // A completion into a buffer beats a release of that buffer in the same cycle.
    always_comb begin
        full_d = full_q & ~i_rel;
        last_d = last_q;
        if (i_set) begin
            full_d[i_set_buf] = 1'b1;
            last_d            = i_set_buf;
        end
    end

    assign pref    = ~last_q;
    assign o_sel   = full_q[pref] ? ~pref : pref;
    assign o_avail = ~(&full_q);
    assign o_full  = full_q;

    // Last-written starts at 1 so the first frame after reset lands in buffer 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q <= 2'b00;
            last_q <= 1'b1;
        end else begin
            full_q <= full_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/resize_sched.sv
// Frame scheduler for the resize downscaler: arms a frame, counts its pixels into a ping-pong buffer.
module resize_sched
    import resize_pkg::*;
#(
    parameter int H_OUTPUT = 418,
    parameter int V_OUTPUT = 258,
    parameter int TIMEOUT  = 6_000_000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    resize_sched_if.slave bus
);

    localparam int               TOTAL    = frame_total(H_OUTPUT, V_OUTPUT);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(TOTAL - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic             start_q, start_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             wr_en_q, wr_en_d;
    logic             wr_buf_q, wr_buf_d;
    logic [PIX_W-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]      wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic             done_buf_q, done_buf_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             sof_seen_q, sof_seen_d;

    logic             tmo_hit;
    logic             buf_avail;
    logic             buf_pick;
    logic [1:0]       buf_full;

    resize_buf_sel u_buf_sel (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rel     (bus.i_buf_rel),
        .i_set     (state_q == ST_DONE),
        .i_set_buf (wr_buf_q),
        .o_full    (buf_full),
        .o_avail   (buf_avail),
        .o_sel     (buf_pick)
    );

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q | bus.i_req;
        start_d    = start_q;
        pix_cnt_d  = pix_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        wr_en_d    = 1'b0;
        wr_buf_d   = wr_buf_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        done_buf_d = done_buf_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        sof_seen_d = sof_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_cont) pend_d = 1'b1;
                // A request arriving in the accept cycle is a new frame and stays pending.
                if (pend_q && buf_avail) begin
                    state_d   = ST_ARM;
                    pend_d    = bus.i_req;
                    start_d   = ~start_q;
                    pix_cnt_d = '0;
                    tmo_cnt_d = '0;
                    wr_buf_d  = buf_pick;
                end
            end
            ST_ARM, ST_RUN: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                // Abort outranks both timeout and the final pixel; the aborted pixel is not written.
                if (bus.i_abort || tmo_hit) begin
                    err_d      = 1'b1;
                    err_code_d = bus.i_abort ? ERR_ABORT : ERR_TIMEOUT;
                    pend_d     = 1'b0;
                    sof_seen_d = 1'b0;
                    state_d    = ST_DRAIN;
                end else if (bus.i_px_de) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_cnt_q;
                    wr_data_d = bus.i_px_data;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    state_d   = (pix_cnt_q == LAST_PIX) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                done_buf_d = wr_buf_q;
                state_d    = ST_IDLE;
            end
            ST_DRAIN: begin
                // Two frame starts guarantee the downscaler has fallen back to its own idle.
                if (bus.i_sof) begin
                    if (sof_seen_q) state_d = ST_IDLE;
                    else            sof_seen_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            start_q    <= 1'b0;
            pix_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_buf_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            done_buf_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            sof_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            start_q    <= start_d;
            pix_cnt_q  <= pix_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_buf_q   <= wr_buf_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            done_buf_q <= done_buf_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            sof_seen_q <= sof_seen_d;
        end
    end

    assign bus.o_start    = start_q;
    assign bus.o_busy     = (state_q != ST_IDLE);
    assign bus.o_wr_en    = wr_en_q;
    assign bus.o_wr_buf   = wr_buf_q;
    assign bus.o_wr_addr  = wr_addr_q;
    assign bus.o_wr_data  = wr_data_q;
    assign bus.o_buf_full = buf_full;
    assign bus.o_done     = done_q;
    assign bus.o_done_buf = done_buf_q;
    assign bus.o_err      = err_q;
    assign bus.o_err_code = err_code_q;
    assign bus.o_state    = state_q;

endmodule

// File: tb/tb_resize_sched.sv
// Bench for resize_sched on a shrunken 8x4 frame with a 200-cycle timeout.
module tb_resize_sched;
    import resize_pkg::*;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int TOT = H * V;
    localparam int TMO = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    resize_sched_if bus ();

    resize_sched #(
        .H_OUTPUT (H),
        .V_OUTPUT (V),
        .TIMEOUT  (TMO)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // expected writes: {buffer, address, data}
    logic [41:0] exp_q[$];
    logic [41:0] exp_w;

    // reference model of buffer ownership
    logic [1:0] m_full;
    logic       m_last;

    // event log filled by the monitor
    int   cyc        = 0;
    int   toggles    = 0;
    int   toggle_cyc = 0;
    int   done_cnt   = 0;
    int   done_cyc   = 0;
    int   err_cnt    = 0;
    int   err_cyc    = 0;
    logic last_done_buf;
    logic [1:0] last_err_code;
    logic prev_start = 1'b0;
    logic prev_final = 1'b0;

    function automatic logic model_pick(input logic [1:0] full, input logic last);
        // prefer the buffer not written last; fall back to the other one
        if (!full[!last]) return !last;
        return last;
    endfunction

    task automatic model_done(input logic b);
        m_full[b] = 1'b1;
        m_last    = b;
    endtask

    task automatic model_rel(input logic [1:0] rel);
        m_full = m_full & ~rel;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_start = 1'b0;
            prev_final = 1'b0;
        end else begin
            if (bus.o_start !== prev_start) begin
                toggles++;
                toggle_cyc = cyc;
                prev_start = bus.o_start;
            end
            if (bus.o_wr_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got buf=%0d addr=%0d data=%06h, required no write",
                             bus.o_wr_buf, bus.o_wr_addr, bus.o_wr_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus.o_wr_buf, bus.o_wr_addr, bus.o_wr_data} !== exp_w) begin
                        failures++;
                        $display("FAIL write: got buf=%0d addr=%0d data=%06h, required buf=%0d addr=%0d data=%06h",
                                 bus.o_wr_buf, bus.o_wr_addr, bus.o_wr_data,
                                 exp_w[41], exp_w[40:24], exp_w[23:0]);
                    end
                end
            end
            if (bus.o_done === 1'b1) begin
                done_cnt++;
                done_cyc      = cyc;
                last_done_buf = bus.o_done_buf;
                checks++;
                if (!prev_final) begin
                    failures++;
                    $display("FAIL done_latency: got o_done without final write in previous cycle, required one cycle after write %0d", TOT - 1);
                end
            end
            if (bus.o_err === 1'b1) begin
                err_cnt++;
                err_cyc       = cyc;
                last_err_code = bus.o_err_code;
            end
            prev_final = (bus.o_wr_en === 1'b1) && (bus.o_wr_addr == 17'(TOT - 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req     = 1'b0;
        bus.i_cont    = 1'b0;
        bus.i_abort   = 1'b0;
        bus.i_sof     = 1'b0;
        bus.i_px_de   = 1'b0;
        bus.i_px_data = '0;
        bus.i_buf_rel = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        exp_q.delete();
        m_full = 2'b00;
        m_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_req();
        bus.i_req = 1'b1;
        tick();
        bus.i_req = 1'b0;
    endtask

    task automatic pulse_rel(input logic [1:0] rel);
        bus.i_buf_rel = rel;
        tick();
        bus.i_buf_rel = 2'b00;
        model_rel(rel);
    endtask

    task automatic drive_pixels(input logic b, input int first, input int n, input int req_at);
        logic [23:0] d;
        for (int i = 0; i < n; i++) begin
            d             = 24'($urandom);
            bus.i_px_de   = 1'b1;
            bus.i_px_data = d;
            bus.i_req     = (i == req_at);
            exp_q.push_back({b, 17'(first + i), d});
            tick();
            bus.i_px_de = 1'b0;
            bus.i_req   = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic wait_toggle(input int target, input int budget, input string name);
        int n = 0;
        while (toggles < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (toggles < target) begin
            failures++;
            $display("FAIL %s: got %0d start toggles after %0d cycles, required %0d", name, toggles, budget, target);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL %s: got %0d done pulses after %0d cycles, required %0d", name, done_cnt, budget, target);
        end
    endtask

    task automatic abort_cycle(input string name);
        bus.i_abort   = 1'b1;
        bus.i_px_de   = 1'b1;
        bus.i_px_data = 24'($urandom);
        tick();
        bus.i_abort = 1'b0;
        bus.i_px_de = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.o_err !== 1'b1 || bus.o_err_code !== ERR_ABORT) begin
            failures++;
            $display("FAIL %s_err: got o_err=%0b code=%0d, required o_err=1 code=2", name, bus.o_err, bus.o_err_code);
        end
    endtask

    task automatic drain_two_sof(input string name);
        bus.i_sof = 1'b1;
        tick();
        bus.i_sof = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_one_sof: got o_busy=%0b, required 1", name, bus.o_busy);
        end
        repeat (3) tick();
        bus.i_sof = 1'b1;
        tick();
        bus.i_sof = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_two_sof: got o_busy=%0b, required 0", name, bus.o_busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (bus.o_start !== 1'b0 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_busy: got start=%0b busy=%0b, required 0 0", bus.o_start, bus.o_busy);
        end
        checks++;
        if ({bus.o_wr_en, bus.o_wr_buf, bus.o_wr_addr, bus.o_wr_data} !== 43'd0) begin
            failures++;
            $display("FAIL reset_write: got en=%0b buf=%0b addr=%0d data=%06h, required all 0",
                     bus.o_wr_en, bus.o_wr_buf, bus.o_wr_addr, bus.o_wr_data);
        end
        checks++;
        if (bus.o_buf_full !== 2'b00) begin
            failures++;
            $display("FAIL reset_buf_full: got %02b, required 00", bus.o_buf_full);
        end
        checks++;
        if ({bus.o_done, bus.o_done_buf, bus.o_err, bus.o_err_code} !== 5'd0) begin
            failures++;
            $display("FAIL reset_done_err: got done=%0b dbuf=%0b err=%0b code=%0d, required all 0",
                     bus.o_done, bus.o_done_buf, bus.o_err, bus.o_err_code);
        end
        checks++;
        if (bus.o_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d, required IDLE", bus.o_state);
        end
        do_reset();
        repeat (5) tick();
        checks++;
        if (bus.o_busy !== 1'b0 || toggles != 0) begin
            failures++;
            $display("FAIL reset_idle_hold: got busy=%0b toggles=%0d, required 0 0", bus.o_busy, toggles);
        end
    endtask

    task automatic test_single_frame();
        logic b;
        int   t0 = toggles;
        int   d0 = done_cnt;
        b = model_pick(m_full, m_last);
        pulse_req();
        wait_toggle(t0 + 1, 10, "single_toggle");
        checks++;
        if (bus.o_start !== 1'b1 || bus.o_wr_buf !== b) begin
            failures++;
            $display("FAIL single_arm: got start=%0b wr_buf=%0b, required 1 %0b", bus.o_start, bus.o_wr_buf, b);
        end
        drive_pixels(b, 0, TOT, -1);
        wait_done(d0 + 1, 10, "single_done");
        model_done(b);
        checks++;
        if (last_done_buf !== b || bus.o_buf_full !== m_full) begin
            failures++;
            $display("FAIL single_result: got done_buf=%0b full=%02b, required %0b %02b",
                     last_done_buf, bus.o_buf_full, b, m_full);
        end
        checks++;
        if (exp_q.size() != 0 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_tail: got missing_writes=%0d busy=%0b, required 0 0", exp_q.size(), bus.o_busy);
        end
    endtask

    task automatic test_cont_stall();
        logic b;
        int   t0;
        int   d0;
        do_reset();
        t0 = toggles;
        d0 = done_cnt;
        bus.i_cont = 1'b1;
        for (int f = 0; f < 2; f++) begin
            b = model_pick(m_full, m_last);
            wait_toggle(t0 + f + 1, 10, "cont_toggle");
            checks++;
            if (bus.o_wr_buf !== b) begin
                failures++;
                $display("FAIL cont_buf: got wr_buf=%0b, required %0b", bus.o_wr_buf, b);
            end
            drive_pixels(b, 0, TOT, -1);
            wait_done(d0 + f + 1, 10, "cont_done");
            model_done(b);
            checks++;
            if (last_done_buf !== b) begin
                failures++;
                $display("FAIL cont_done_buf: got %0b, required %0b", last_done_buf, b);
            end
        end
        repeat (30) tick();
        checks++;
        if (bus.o_busy !== 1'b0 || toggles != t0 + 2 || bus.o_buf_full !== 2'b11) begin
            failures++;
            $display("FAIL cont_stall: got busy=%0b toggles=%0d full=%02b, required 0 %0d 11",
                     bus.o_busy, toggles - t0, bus.o_buf_full, 2);
        end
        pulse_rel(2'b01);
        b = model_pick(m_full, m_last);
        wait_toggle(t0 + 3, 10, "cont_after_rel_toggle");
        bus.i_cont = 1'b0;
        checks++;
        if (bus.o_wr_buf !== b) begin
            failures++;
            $display("FAIL cont_after_rel_buf: got %0b, required %0b", bus.o_wr_buf, b);
        end
        drive_pixels(b, 0, TOT, -1);
        wait_done(d0 + 3, 10, "cont_after_rel_done");
        model_done(b);
        checks++;
        if (bus.o_buf_full !== m_full) begin
            failures++;
            $display("FAIL cont_final_full: got %02b, required %02b", bus.o_buf_full, m_full);
        end
    endtask

    task automatic test_abort();
        logic b;
        int   t0 = toggles;
        int   d0 = done_cnt;
        pulse_rel(2'b11);
        @(negedge clk);
        #1;
        checks++;
        if (bus.o_buf_full !== m_full) begin
            failures++;
            $display("FAIL release_all: got %02b, required %02b", bus.o_buf_full, m_full);
        end
        b = model_pick(m_full, m_last);
        pulse_req();
        wait_toggle(t0 + 1, 10, "abort_toggle");
        drive_pixels(b, 0, 5, -1);
        abort_cycle("abort");
        for (int i = 0; i < 5; i++) begin
            bus.i_px_de   = 1'b1;
            bus.i_px_data = 24'($urandom);
            tick();
        end
        bus.i_px_de = 1'b0;
        drain_two_sof("abort");
        checks++;
        if (bus.o_buf_full !== m_full || done_cnt != d0 || toggles != t0 + 1) begin
            failures++;
            $display("FAIL abort_after: got full=%02b dones=%0d toggles=%0d, required %02b 0 1",
                     bus.o_buf_full, done_cnt - d0, toggles - t0, m_full);
        end
    endtask

    task automatic test_timeout();
        int t0 = toggles;
        int e0 = err_cnt;
        int n  = 0;
        pulse_req();
        wait_toggle(t0 + 1, 10, "timeout_toggle");
        while (err_cnt == e0 && n < TMO + 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (err_cnt == e0 || err_cyc - toggle_cyc != TMO || last_err_code !== ERR_TIMEOUT) begin
            failures++;
            $display("FAIL timeout: got errs=%0d delay=%0d code=%0d, required 1 %0d 1",
                     err_cnt - e0, err_cyc - toggle_cyc, last_err_code, TMO);
        end
        drain_two_sof("timeout");
    endtask

    task automatic test_abort_final();
        logic b;
        int   t0 = toggles;
        int   d0 = done_cnt;
        b = model_pick(m_full, m_last);
        pulse_req();
        wait_toggle(t0 + 1, 10, "abort_final_toggle");
        drive_pixels(b, 0, TOT - 1, -1);
        abort_cycle("abort_final");
        repeat (5) tick();
        checks++;
        if (done_cnt != d0 || bus.o_buf_full !== m_full) begin
            failures++;
            $display("FAIL abort_final_after: got dones=%0d full=%02b, required 0 %02b",
                     done_cnt - d0, bus.o_buf_full, m_full);
        end
        drain_two_sof("abort_final");
    endtask

    task automatic test_back_to_back();
        logic b1;
        logic b2;
        int   t0 = toggles;
        int   d0 = done_cnt;
        b1 = model_pick(m_full, m_last);
        pulse_req();
        wait_toggle(t0 + 1, 10, "b2b_toggle1");
        drive_pixels(b1, 0, TOT, 10);
        wait_done(d0 + 1, 10, "b2b_done1");
        model_done(b1);
        b2 = model_pick(m_full, m_last);
        wait_toggle(t0 + 2, 4, "b2b_toggle2");
        checks++;
        if (toggle_cyc - done_cyc < 1 || toggle_cyc - done_cyc > 2 || bus.o_wr_buf !== b2) begin
            failures++;
            $display("FAIL b2b_rearm: got gap=%0d wr_buf=%0b, required gap 1..2 buf %0b",
                     toggle_cyc - done_cyc, bus.o_wr_buf, b2);
        end
        drive_pixels(b2, 0, TOT, -1);
        wait_done(d0 + 2, 10, "b2b_done2");
        model_done(b2);
        repeat (10) tick();
        checks++;
        if (toggles != t0 + 2 || last_done_buf !== b2 || bus.o_buf_full !== m_full) begin
            failures++;
            $display("FAIL b2b_result: got toggles=%0d done_buf=%0b full=%02b, required 2 %0b %02b",
                     toggles - t0, last_done_buf, bus.o_buf_full, b2, m_full);
        end
    endtask

    task automatic test_reset_midframe();
        logic b;
        int   t0;
        pulse_rel(2'b11);
        t0 = toggles;
        b  = model_pick(m_full, m_last);
        pulse_req();
        wait_toggle(t0 + 1, 10, "mid_toggle");
        drive_pixels(b, 0, 3, -1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_start !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_wr_en !== 1'b0 || bus.o_wr_addr !== 17'd0) begin
            failures++;
            $display("FAIL mid_reset: got start=%0b busy=%0b wr_en=%0b addr=%0d, required 0 0 0 0",
                     bus.o_start, bus.o_busy, bus.o_wr_en, bus.o_wr_addr);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_writes: got %0d missing writes, required 0", exp_q.size());
        end
        do_reset();
        t0 = toggles;
        repeat (10) tick();
        checks++;
        if (bus.o_busy !== 1'b0 || toggles != t0) begin
            failures++;
            $display("FAIL mid_after_reset: got busy=%0b toggles=%0d, required 0 0", bus.o_busy, toggles - t0);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_frame();
        test_cont_stall();
        test_abort();
        test_timeout();
        test_abort_final();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
